// File: rtl/anim_frame_sched.sv
// anim_frame_sched: tile raster address generator with animation frame sequencing.
// Ports: clk_i/rst_i/cen_i, fvht_i timing, play_i/step_i/rate_i/nframes_i control;
//        addr_o ROM address, frame_o, frame_start_o, state_o.
module anim_frame_sched #(
  parameter int X_RES      = 96,
  parameter int Y_RES      = 54,
  parameter int TILE       = 21,
  parameter int MAX_FRAMES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [3:0]  fvht_i,
  input  logic        play_i,
  input  logic        step_i,
  input  logic [3:0]  rate_i,
  input  logic [2:0]  nframes_i,
  output logic [15:0] addr_o,
  output logic [2:0]  frame_o,
  output logic        frame_start_o,
  output logic [1:0]  state_o
);

  localparam int TW = $clog2(TILE);
  localparam int CW = $clog2(X_RES);
  localparam int RW = $clog2(Y_RES);

  localparam logic [TW-1:0] T_LAST = TW'(TILE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(X_RES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(Y_RES - 1);
  localparam logic [2:0]    N_MAX  = 3'(MAX_FRAMES);
  localparam logic [15:0]   XR     = 16'(X_RES);
  localparam logic [15:0]   FSZ    = 16'(X_RES * Y_RES);

  typedef enum logic [1:0] {
    PAUSE     = 2'd0,
    PLAY      = 2'd1,
    STEP_WAIT = 2'd2
  } state_t;

  state_t state, state_d;

  logic          h_q, v_q;
  logic          h_rise, v_rise;
  logic [TW-1:0] px, ln;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0]    vcnt, vcnt_d, eff_rate;
  logic [2:0]    frame, frame_d, frame_nx, eff_n;
  logic [15:0]   addr_q;
  logic          fstart_q;
  logic          unused;

  assign unused = fvht_i[3] ^ fvht_i[0];
  assign h_rise = fvht_i[1] & ~h_q;
  assign v_rise = fvht_i[2] & ~v_q;

  // Raster position. A coincident V edge overrides the H edge for
  // row/line, while col still restarts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q <= 1'b0;
      v_q <= 1'b0;
      px  <= '0;
      ln  <= '0;
      col <= '0;
      row <= '0;
    end else if (cen_i) begin
      h_q <= fvht_i[1];
      v_q <= fvht_i[2];
      if (h_rise) begin
        px  <= '0;
        col <= '0;
        if (!v_rise) begin
          if (ln == T_LAST) begin
            ln <= '0;
            if (row != R_LAST) row <= row + RW'(1);
          end else begin
            ln <= ln + TW'(1);
          end
        end
      end else if (!fvht_i[1]) begin
        if (px == T_LAST) begin
          px <= '0;
          if (col != C_LAST) col <= col + CW'(1);
        end else begin
          px <= px + TW'(1);
        end
      end
      if (v_rise) begin
        row <= '0;
        ln  <= '0;
      end
    end
  end

  // Rate and frame count are used live at the V edge only.
  always_comb begin
    eff_rate = (rate_i == 4'd0) ? 4'd1 : rate_i;
    if (nframes_i == 3'd0)
      eff_n = 3'd1;
    else if (nframes_i > N_MAX)
      eff_n = N_MAX;
    else
      eff_n = nframes_i;
    // >= also catches a frame left beyond a shrunk frame count
    frame_nx = (frame >= eff_n - 3'd1) ? 3'd0 : frame + 3'd1;
  end

  always_comb begin
    state_d = state;
    frame_d = frame;
    vcnt_d  = vcnt;
    unique case (state)
      PAUSE: begin
        vcnt_d = '0;
        if (play_i)
          state_d = PLAY;
        else if (step_i)
          state_d = STEP_WAIT;
      end
      PLAY: begin
        if (!play_i) begin
          state_d = PAUSE;
          vcnt_d  = '0;
        end else if (v_rise) begin
          if (vcnt >= eff_rate - 4'd1) begin
            vcnt_d  = '0;
            frame_d = frame_nx;
          end else begin
            vcnt_d = vcnt + 4'd1;
          end
        end
      end
      STEP_WAIT: begin
        vcnt_d = '0;
        if (v_rise) begin
          frame_d = frame_nx;
          state_d = play_i ? PLAY : PAUSE;
        end
      end
      default: begin
        state_d = PAUSE;
        vcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= PAUSE;
      frame    <= '0;
      vcnt     <= '0;
      addr_q   <= '0;
      fstart_q <= 1'b0;
    end else if (cen_i) begin
      state    <= state_d;
      frame    <= frame_d;
      vcnt     <= vcnt_d;
      fstart_q <= v_rise;
      addr_q   <= 16'(row) * XR + 16'(col) + 16'(frame) * FSZ;
    end
  end

  assign addr_o        = addr_q;
  assign frame_o       = frame;
  assign frame_start_o = fstart_q;
  assign state_o       = state;

endmodule

// File: tb/tb_anim_frame_sched.sv
// tb_anim_frame_sched: vector table, directed scenarios and random
// stimulus against a behavioural model of anim_frame_sched.
module tb_anim_frame_sched;

  localparam int X  = 96;
  localparam int Y  = 54;
  localparam int T  = 21;
  localparam int MF = 4;
  localparam int N  = 600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [3:0]  fvht = '0;
  logic        play = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  rate = 4'd1;
  logic [2:0]  nfr = 3'd1;
  logic [15:0] addr_o;
  logic [2:0]  frame_o;
  logic        frame_start_o;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;

  anim_frame_sched #(
    .X_RES(X), .Y_RES(Y), .TILE(T), .MAX_FRAMES(MF)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cen_i(cen),
    .fvht_i(fvht),
    .play_i(play),
    .step_i(step),
    .rate_i(rate),
    .nframes_i(nfr),
    .addr_o(addr_o),
    .frame_o(frame_o),
    .frame_start_o(frame_start_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: positions as counts of events, frame sequencing
  // as counts of vsyncs since the last advance.
  int m_x, m_y, m_frame, m_cnt, m_mode, m_addr, m_fs;
  bit m_ph, m_pv;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_step();
    bit h, v, hr, vr;
    int effr, effn, nxt;
    if (rst) begin
      m_x = 0; m_y = 0; m_frame = 0; m_cnt = 0;
      m_mode = 0; m_addr = 0; m_fs = 0;
      m_ph = 0; m_pv = 0;
    end else if (cen) begin
      h = fvht[1];
      v = fvht[2];
      hr = h && !m_ph;
      vr = v && !m_pv;
      effr = (rate == 0) ? 1 : int'(rate);
      effn = (nfr == 0) ? 1 : imin(int'(nfr), MF);
      nxt = (m_frame + 1 >= effn) ? 0 : m_frame + 1;
      m_addr = (imin(m_x / T, X - 1)
              + imin(m_y / T, Y - 1) * X
              + m_frame * X * Y) & 16'hffff;
      m_fs = vr ? 1 : 0;
      if (hr) m_x = 0;
      else if (!h) m_x++;
      if (vr) m_y = 0;
      else if (hr) m_y++;
      case (m_mode)
        0: begin
          if (play) m_mode = 1;
          else if (step) m_mode = 2;
        end
        1: begin
          if (!play) begin
            m_mode = 0;
            m_cnt = 0;
          end else if (vr) begin
            m_cnt++;
            if (m_cnt >= effr) begin
              m_cnt = 0;
              m_frame = nxt;
            end
          end
        end
        default: begin
          if (vr) begin
            m_frame = nxt;
            m_mode = play ? 1 : 0;
          end
        end
      endcase
      m_ph = h;
      m_pv = v;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("m_addr", int'(addr_o), m_addr);
    chk("m_frame", int'(frame_o), m_frame);
    chk("m_fstart", int'(frame_start_o), m_fs);
    chk("m_state", int'(state_o), m_mode);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cen = 1'b0;
    fvht = '0;
    play = 1'b0;
    step = 1'b0;
    cyc();
    rst = 1'b0;
    cen = 1'b1;
  endtask

  task automatic vpulse();
    fvht = 4'd4;
    cyc();
    fvht = 4'd0;
    cyc();
  endtask

  typedef struct {
    bit         rst;
    bit         cen;
    logic [3:0] fvht;
    bit         play;
    bit         step;
    logic [3:0] rate;
    logic [2:0] nfr;
    int         fr;
    int         st;
    int         fs;
  } vec_t;

  typedef struct {
    logic [3:0] fvht;
    bit         play;
    bit         step;
    logic [3:0] rate;
    logic [2:0] nfr;
  } rv_t;

  vec_t tbl [16];
  rv_t  rv [N];
  logic [21:0] out1 [N];

  task automatic apply_rv(input int i);
    fvht = rv[i].fvht;
    play = rv[i].play;
    step = rv[i].step;
    rate = rv[i].rate;
    nfr  = rv[i].nfr;
  endtask

  initial begin
    int prev, steps, f;

    tbl[0]  = '{1, 0, 4'd0, 0, 0, 4'd1, 3'd2, 0, 0, 0};
    tbl[1]  = '{0, 1, 4'd0, 0, 0, 4'd1, 3'd2, 0, 0, 0};
    tbl[2]  = '{0, 1, 4'd4, 0, 0, 4'd1, 3'd2, 0, 0, 1};
    tbl[3]  = '{0, 1, 4'd0, 0, 1, 4'd1, 3'd2, 0, 2, 0};
    tbl[4]  = '{0, 1, 4'd0, 0, 1, 4'd1, 3'd2, 0, 2, 0};
    tbl[5]  = '{0, 1, 4'd4, 0, 0, 4'd1, 3'd2, 1, 0, 1};
    tbl[6]  = '{0, 1, 4'd4, 1, 0, 4'd1, 3'd2, 1, 1, 0};
    tbl[7]  = '{0, 1, 4'd0, 1, 0, 4'd1, 3'd2, 1, 1, 0};
    tbl[8]  = '{0, 1, 4'd4, 1, 0, 4'd1, 3'd2, 0, 1, 1};
    tbl[9]  = '{0, 1, 4'd0, 1, 0, 4'd1, 3'd2, 0, 1, 0};
    tbl[10] = '{0, 0, 4'd4, 1, 0, 4'd1, 3'd2, 0, 1, 0};
    tbl[11] = '{0, 1, 4'd4, 1, 0, 4'd1, 3'd2, 1, 1, 1};
    tbl[12] = '{0, 1, 4'd0, 1, 0, 4'd1, 3'd0, 1, 1, 0};
    tbl[13] = '{0, 1, 4'd4, 1, 0, 4'd1, 3'd0, 0, 1, 1};
    tbl[14] = '{0, 1, 4'd0, 0, 0, 4'd1, 3'd0, 0, 0, 0};
    tbl[15] = '{0, 1, 4'd4, 0, 0, 4'd1, 3'd0, 0, 0, 1};

    for (int i = 0; i < 16; i++) begin
      rst  = tbl[i].rst;
      cen  = tbl[i].cen;
      fvht = tbl[i].fvht;
      play = tbl[i].play;
      step = tbl[i].step;
      rate = tbl[i].rate;
      nfr  = tbl[i].nfr;
      cyc();
      chk($sformatf("tbl%0d_frame", i), int'(frame_o), tbl[i].fr);
      chk($sformatf("tbl%0d_state", i), int'(state_o), tbl[i].st);
      chk($sformatf("tbl%0d_fstart", i),
          int'(frame_start_o), tbl[i].fs);
    end
    chk("reset_addr_seen", int'(addr_o), 0);

    // One raster line: col walks 0..95 and saturates.
    do_reset();
    prev = 0;
    steps = 0;
    for (int k = 0; k < X * T; k++) begin
      cyc();
      if (int'(addr_o) != prev) begin
        chk("col_step", int'(addr_o), prev + 1);
        steps++;
        prev = int'(addr_o);
      end
    end
    chk("col_steps", steps, X - 1);
    chk("col_last", int'(addr_o), X - 1);
    fvht = 4'd2;
    cyc();
    chk("hpulse_addr", int'(addr_o), X - 1);
    fvht = 4'd0;
    cyc();
    chk("line1_addr", int'(addr_o), 0);

    // Playback at rate 8 over 4 frames.
    do_reset();
    play = 1'b1;
    rate = 4'd8;
    nfr = 3'd4;
    cyc();
    for (int p = 1; p <= 40; p++) begin
      fvht = 4'd4;
      cyc();
      chk("play_fstart", int'(frame_start_o), 1);
      fvht = 4'd0;
      cyc();
      cyc();
      chk("play_frame", int'(frame_o), (p / 8) % 4);
    end

    // Coincident H and V edges at a nonzero row/col.
    play = 1'b0;
    cyc();
    for (int r = 0; r < 25; r++) begin
      fvht = 4'd0;
      cyc(); cyc(); cyc();
      fvht = 4'd2;
      cyc();
    end
    fvht = 4'd0;
    for (int k = 0; k < 50; k++) cyc();
    chk("pre_simul_addr", int'(addr_o), 5184 + X + 2);
    fvht = 4'd6;
    cyc();
    fvht = 4'd0;
    cyc();
    chk("simul_addr", int'(addr_o), 5184);

    // Pause and step.
    step = 1'b1;
    cyc();
    step = 1'b0;
    cyc();
    chk("step_wait_frame", int'(frame_o), 1);
    step = 1'b1;
    cyc();
    step = 1'b0;
    vpulse();
    chk("step_frame", int'(frame_o), 2);
    chk("step_state", int'(state_o), 0);

    // Reset during playback at frame 2.
    do_reset();
    play = 1'b1;
    rate = 4'd1;
    nfr = 3'd4;
    cyc();
    vpulse();
    vpulse();
    chk("rst_pre_frame", int'(frame_o), 2);
    for (int k = 0; k < 30; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_frame", int'(frame_o), 0);
    chk("rst_state", int'(state_o), 0);
    chk("rst_addr", int'(addr_o), 0);
    rate = 4'd2;
    cyc();
    chk("rst_play", int'(state_o), 1);
    vpulse();
    chk("rst_v1", int'(frame_o), 0);
    vpulse();
    chk("rst_v2", int'(frame_o), 1);

    // Rate 0 / nframes 0, then nframes above the ROM size.
    do_reset();
    play = 1'b1;
    rate = 4'd0;
    nfr = 3'd0;
    cyc();
    for (int p = 0; p < 5; p++) begin
      fvht = 4'd4;
      cyc();
      chk("n0_fstart", int'(frame_start_o), 1);
      fvht = 4'd0;
      cyc();
      chk("n0_frame", int'(frame_o), 0);
    end
    nfr = 3'd7;
    for (int p = 1; p <= 6; p++) begin
      vpulse();
      chk("n7_frame", int'(frame_o), p % 4);
    end

    // Clock-enable equivalence on a random vector set.
    for (int i = 0; i < N; i++) begin
      rv[i].fvht = {1'b0,
                    1'($urandom_range(11) == 0),
                    1'($urandom_range(7) == 0),
                    1'b0};
      rv[i].play = ((i / 97) % 3) != 0;
      rv[i].step = $urandom_range(19) == 0;
      rv[i].rate = 4'($urandom_range(2));
      rv[i].nfr  = 3'($urandom_range(7));
    end
    do_reset();
    for (int i = 0; i < N; i++) begin
      apply_rv(i);
      cyc();
      out1[i] = {addr_o, frame_o, frame_start_o, state_o};
    end
    do_reset();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(1) == 1) begin
        cen = 1'b0;
        fvht = 4'($urandom);
        play = 1'($urandom);
        step = 1'($urandom);
        cyc();
      end
      cen = 1'b1;
      apply_rv(i);
      cyc();
      chk("cen_equiv",
          int'({addr_o, frame_o, frame_start_o, state_o}),
          int'(out1[i]));
    end

    // Free random run, model only.
    f = 0;
    for (int i = 0; i < 3000; i++) begin
      rst  = $urandom_range(499) == 0;
      cen  = $urandom_range(3) != 0;
      fvht = {1'b0,
              1'($urandom_range(9) == 0),
              1'($urandom_range(5) == 0),
              1'b0};
      if ($urandom_range(49) == 0) f = 1 - f;
      play = f[0];
      step = $urandom_range(15) == 0;
      if ($urandom_range(99) == 0) rate = 4'($urandom_range(3));
      if ($urandom_range(99) == 0) nfr = 3'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
